// File: rtl/tt_stim_pkg.sv
// Shared types for the pin stimulus/response checker: FSM states and stimulus mode codes.
package tt_stim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DUT_RST,
        DRIVE,
        SETTLE,
        CAPTURE,
        CHECK,
        DONE
    } state_t;

    localparam logic [1:0] MODE_CNT  = 2'd0;
    localparam logic [1:0] MODE_LFSR = 2'd1;
    localparam logic [1:0] MODE_WALK = 2'd2;

endpackage

// File: rtl/tt_shift_fb.sv
// One combinational step of a Galois shift register with feedback taps POLY.
// rotate=1 wraps the MSB into bit 0 (MISR); rotate=0 shifts in zero (LFSR).
module tt_shift_fb #(
    parameter int             W    = 8,
    parameter logic [W-1:0]   POLY = 8'h1D
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] din,
    input  logic         rotate,
    output logic [W-1:0] nxt
);

    assign nxt = {cur[W-2:0], rotate & cur[W-1]} ^ din ^ (cur[W-1] ? POLY : '0);

endmodule

// File: rtl/tt_pin_stim_checker.sv
// On-chip self-test beside a tt_um-style design: drives counter/LFSR/walking-one vectors, MISR-compacts responses.
// Optional STIM_HOLD_EN adds a hold input that freezes sequencing during DRIVE/SETTLE/CAPTURE.
module tt_pin_stim_checker
    import tt_stim_pkg::*;
#(
    parameter int                  DATA_W     = 8,
    parameter int                  NUM_VEC    = 16,
    parameter int                  RST_CYC    = 2,
    parameter int                  SETTLE_CYC = 1,
    parameter logic [DATA_W-1:0]   POLY       = 8'h1D
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
`ifdef STIM_HOLD_EN
    input  logic                           hold,
`endif
    input  logic [1:0]                     mode,
    input  logic [DATA_W-1:0]              seed,
    input  logic [DATA_W-1:0]              expected_sig,
    input  logic [DATA_W-1:0]              uo_out,
    input  logic [DATA_W-1:0]              uio_out,
    input  logic [DATA_W-1:0]              uio_oe,
    output logic [DATA_W-1:0]              ui_in,
    output logic [DATA_W-1:0]              uio_in,
    output logic                           dut_ena,
    output logic                           dut_rst_n,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [DATA_W-1:0]              signature,
    output logic [$clog2(NUM_VEC+1)-1:0]   vec_idx
);

    localparam int          VIDX_W      = $clog2(NUM_VEC + 1);
    localparam logic [15:0] RST_LAST    = 16'(RST_CYC - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [VIDX_W-1:0] VIDX_LAST = VIDX_W'(NUM_VEC - 1);

    state_t              state, state_nxt;
    logic [15:0]         cnt;
    logic [1:0]          mode_r;
    logic [DATA_W-1:0]   lfsr, lfsr_nxt, misr_nxt, resp;
    logic [DATA_W-1:0]   vec, vec_rev;
    logic                stall;
    logic                start_ok;

`ifdef STIM_HOLD_EN
    assign stall = hold & ((state == DRIVE) | (state == SETTLE) | (state == CAPTURE));
`else
    assign stall = 1'b0;
`endif

    assign start_ok = start & ((state == IDLE) | (state == DONE));
    assign resp     = uo_out ^ (uio_out & uio_oe);

    tt_shift_fb #(.W(DATA_W), .POLY(POLY)) u_lfsr_step (
        .cur    (lfsr),
        .din    ('0),
        .rotate (1'b0),
        .nxt    (lfsr_nxt)
    );

    tt_shift_fb #(.W(DATA_W), .POLY(POLY)) u_misr_step (
        .cur    (signature),
        .din    (resp),
        .rotate (1'b1),
        .nxt    (misr_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = DUT_RST;
            DUT_RST: if (cnt == RST_LAST) state_nxt = DRIVE;
            DRIVE: begin
                if (!stall) begin
                    if (SETTLE_CYC == 0) state_nxt = CAPTURE;
                    else                 state_nxt = SETTLE;
                end
            end
            SETTLE:  if (!stall && cnt == SETTLE_LAST) state_nxt = CAPTURE;
            CAPTURE: begin
                if (!stall) begin
                    if (vec_idx == VIDX_LAST) state_nxt = CHECK;
                    else                      state_nxt = DRIVE;
                end
            end
            CHECK:   state_nxt = DONE;
            DONE:    if (start_ok) state_nxt = DUT_RST;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            DUT_RST, DRIVE, SETTLE, CAPTURE, CHECK: busy = 1'b1;
            DONE:                                   done = 1'b1;
            default: ;
        endcase
    end

    // Vector for the current index; mode 3 falls back to the counter pattern.
    always_comb begin
        case (mode_r)
            MODE_LFSR: vec = lfsr;
            MODE_WALK: vec = {{(DATA_W-1){1'b0}}, 1'b1} << (32'(vec_idx) % DATA_W);
            MODE_CNT:  vec = DATA_W'(vec_idx);
            default:   vec = DATA_W'(vec_idx);
        endcase
    end

    always_comb begin
        vec_rev = '0;
        for (int b = 0; b < DATA_W; b++) begin
            vec_rev[b] = vec[DATA_W-1-b];
        end
    end

    // Dwell counter restarts on every state change so each state times itself from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (!stall) begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r    <= MODE_CNT;
            lfsr      <= '0;
            ui_in     <= '0;
            uio_in    <= '0;
            dut_ena   <= 1'b0;
            dut_rst_n <= 1'b0;
            pass      <= 1'b0;
            signature <= '0;
            vec_idx   <= '0;
        end else begin
            if (start_ok) begin
                mode_r    <= mode;
                lfsr      <= (seed == '0) ? DATA_W'(1) : seed;
                signature <= '0;
                vec_idx   <= '0;
                pass      <= 1'b0;
                dut_ena   <= 1'b1;
                dut_rst_n <= 1'b0;
            end
            if (state == DRIVE && !stall) begin
                ui_in     <= vec;
                uio_in    <= vec_rev;
                dut_rst_n <= 1'b1;
            end
            if (state == CAPTURE && !stall) begin
                signature <= misr_nxt;
                vec_idx   <= vec_idx + 1'b1;
                lfsr      <= lfsr_nxt;
            end
            if (state == CHECK) begin
                pass <= (signature == expected_sig);
            end
        end
    end

endmodule

// File: tb/tb_tt_pin_stim_checker.sv
// Bench for tt_pin_stim_checker: directed cases plus randomized runs against a vector/MISR reference model.
module tb_tt_pin_stim_checker;

    localparam logic [7:0] POLY = 8'h1D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start9;
    logic [1:0] mode, mode9;
    logic [7:0] seed, seed9, exp_sig, exp_sig9;
`ifdef STIM_HOLD_EN
    logic       hold, hold9;
`endif
    logic       lb_en;
    logic [7:0] k1, k2, k3;

    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe, signature;
    logic       dut_ena, dut_rst_n, busy, done, pass;
    logic [2:0] vec_idx;

    logic [7:0] ui_in9, uio_in9, uo_out9, uio_out9, uio_oe9, signature9;
    logic       dut_ena9, dut_rst_n9, busy9, done9, pass9;
    logic [3:0] vec_idx9;

    // Stand-in user design: optional loopback with xor masks, bidir partially enabled.
    assign uo_out   = lb_en ? (ui_in ^ k1) : k1;
    assign uio_out  = uio_in ^ k3;
    assign uio_oe   = k2;
    assign uo_out9  = lb_en ? (ui_in9 ^ k1) : k1;
    assign uio_out9 = uio_in9 ^ k3;
    assign uio_oe9  = k2;

    tt_pin_stim_checker #(.DATA_W(8), .NUM_VEC(4), .RST_CYC(2), .SETTLE_CYC(1), .POLY(POLY)) u_dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef STIM_HOLD_EN
        .hold(hold),
`endif
        .mode(mode), .seed(seed), .expected_sig(exp_sig),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
        .ui_in(ui_in), .uio_in(uio_in), .dut_ena(dut_ena), .dut_rst_n(dut_rst_n),
        .busy(busy), .done(done), .pass(pass), .signature(signature), .vec_idx(vec_idx)
    );

    tt_pin_stim_checker #(.DATA_W(8), .NUM_VEC(9), .RST_CYC(2), .SETTLE_CYC(1), .POLY(POLY)) u_dut9 (
        .clk(clk), .rst(rst), .start(start9),
`ifdef STIM_HOLD_EN
        .hold(hold9),
`endif
        .mode(mode9), .seed(seed9), .expected_sig(exp_sig9),
        .uo_out(uo_out9), .uio_out(uio_out9), .uio_oe(uio_oe9),
        .ui_in(ui_in9), .uio_in(uio_in9), .dut_ena(dut_ena9), .dut_rst_n(dut_rst_n9),
        .busy(busy9), .done(done9), .pass(pass9), .signature(signature9), .vec_idx(vec_idx9)
    );

    int n_vec = 0;
    int n_err = 0;

    int mv[16];
    int msig;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int b = 0; b < 8; b++) begin
            if (((v >> b) & 1) != 0) r |= (1 << (7 - b));
        end
        return r;
    endfunction

    function automatic int resp_of(input int v);
        int uo  = lb_en ? (v ^ int'(k1)) : int'(k1);
        int uio = brev(v) ^ int'(k3);
        return (uo ^ (uio & int'(k2))) & 255;
    endfunction

    // Reference: list of vectors per mode and the MISR signature over the responses.
    task automatic model(input int md, input int sd, input int n);
        int l = (sd == 0) ? 1 : sd;
        int s = 0;
        int top;
        for (int i = 0; i < n; i++) begin
            if (md == 1)      mv[i] = l;
            else if (md == 2) mv[i] = 1 << (i % 8);
            else              mv[i] = i % 256;
            top = (s >> 7) & 1;
            s = (((s << 1) & 255) | top) ^ resp_of(mv[i]);
            if (top != 0) s ^= int'(POLY);
            top = (l >> 7) & 1;
            l = (l << 1) & 255;
            if (top != 0) l ^= int'(POLY);
        end
        msig = s;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ui_in"}, ui_in, 0);
        chk({tag, "_uio_in"}, uio_in, 0);
        chk({tag, "_ena"}, dut_ena, 0);
        chk({tag, "_rst_n"}, dut_rst_n, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_sig"}, signature, 0);
        chk({tag, "_vidx"}, vec_idx, 0);
    endtask

    task automatic run(input int md, input int sd, input bit good, input logic [7:0] bad,
                       input int glitch, input int hlen);
        int         cyc = 0;
        int         tgt;
        logic [7:0] es;
        model(md, sd, 4);
        es = good ? 8'(msig) : bad;
        mode = 2'(md); seed = 8'(sd); exp_sig = es;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 2'($urandom); seed = 8'($urandom);
        chk("busy_in_rst", busy, 1);
        chk("rst_n_low", dut_rst_n, 0);
        chk("ena_on", dut_ena, 1);
        chk("sig_cleared", signature, 0);
        tgt = 2 + 4 * 3 + 1 + hlen;
        while (!done && cyc < tgt + 20) begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (cyc == 3 + 3 * i + ((i > 0) ? hlen : 0)) begin
                    chk("ui_in", ui_in, mv[i]);
                    chk("uio_in", uio_in, brev(mv[i]));
                end
            end
            start = (glitch > 0 && cyc == glitch);
`ifdef STIM_HOLD_EN
            if (hlen > 0 && cyc == 3) hold = 1'b1;
            if (hlen > 0 && cyc == 3 + hlen) hold = 1'b0;
`endif
        end
        start = 1'b0;
        chk("done", done, 1);
        chk("latency", cyc, tgt);
        chk("signature", signature, msig);
        chk("pass", pass, (es == 8'(msig)));
        chk("vec_idx", vec_idx, 4);
        chk("busy_done", busy, 0);
        chk("rst_n_high", dut_rst_n, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("done_held", done, 1);
        chk("pins_held", ui_in, mv[3]);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; start9 = 1'b0;
        mode = 2'd0; mode9 = 2'd0; seed = 8'd0; seed9 = 8'd0; exp_sig = 8'd0; exp_sig9 = 8'd0;
        lb_en = 1'b1; k1 = 8'd0; k2 = 8'd0; k3 = 8'd0;
`ifdef STIM_HOLD_EN
        hold = 1'b0; hold9 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // counter loopback, golden 03
        run(0, 0, 1'b1, 8'h00, 0, 0);
        chk("c1_sig_const", signature, 8'h03);
        chk("c1_pass_const", pass, 1);

        // walking-one with bidir echo
        lb_en = 1'b0; k1 = 8'h00; k2 = 8'hFF; k3 = 8'h00;
        run(2, 0, 1'b1, 8'h00, 0, 0);

        // wrong golden value
        lb_en = 1'b1; k2 = 8'h00;
        run(0, 0, 1'b0, 8'h04, 0, 0);
        chk("c4_pass_low", pass, 0);
        chk("c4_sig_const", signature, 8'h03);

        // start pulse while busy is ignored
        run(0, 0, 1'b1, 8'h00, 5, 0);
`ifdef STIM_HOLD_EN
        run(0, 0, 1'b1, 8'h00, 0, 5);
`endif

        // rst while vector 2 is on the pins
        mode = 2'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 9) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_vec2", ui_in, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset("mid_rst");
        rst = 1'b0;
        @(posedge clk); #1;
        run(0, 0, 1'b1, 8'h00, 0, 0);

        repeat (25) begin
            lb_en = 1'($urandom);
            k1 = 8'($urandom); k2 = 8'($urandom); k3 = 8'($urandom);
            run($urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
                1'($urandom), 8'($urandom), $urandom_range(0, 12), 0);
        end

        // nine-vector LFSR run with seed 0
        lb_en = 1'b1; k1 = 8'h00; k2 = 8'h00; k3 = 8'h00;
        model(1, 0, 9);
        mode9 = 2'd1; seed9 = 8'h00; exp_sig9 = 8'(msig);
        start9 = 1'b1;
        @(posedge clk); #1;
        start9 = 1'b0;
        cyc = 0;
        while (!done9 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < 9; i++) begin
                if (cyc == 3 + 3 * i) begin
                    chk("lfsr_ui_in", ui_in9, mv[i]);
                    chk("lfsr_uio_in", uio_in9, brev(mv[i]));
                end
            end
        end
        chk("lfsr_last_1d", ui_in9, 8'h1D);
        chk("lfsr_last_rev", uio_in9, 8'hB8);
        chk("lfsr_latency", cyc, 30);
        chk("lfsr_sig", signature9, msig);
        chk("lfsr_pass", pass9, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
